// File: rtl/hsst_tx_framer.sv
// hsst_tx_framer
//   Read side of hsst_fifo. Pulls 16-bit video words out of the FIFO and wraps
//   each group of PKT_WORDS words in a packet for one HSST TX lane:
//     SOP {seq,K27.7} | PKT_WORDS payload | checksum | EOP K29.7 | IDLE_GAP idles
//   The FIFO read port has a 1-cycle read latency. The payload word that
//   returns is registered once more onto txdata, so a read issued in cycle t
//   appears on txdata in cycle t+2.
//   A payload slot with no returning word carries a K28.5 idle (fill). Fill
//   does not advance the payload, so word order is preserved across stalls.
//
//   Legal parameter ranges: PKT_WORDS 2..1024, IDLE_GAP 1..255.

module hsst_tx_framer #(
   parameter int PKT_WORDS = 256,
   parameter int IDLE_GAP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        link_ready,
   output logic        fifo_rd_en,
   input  logic [15:0] fifo_rd_data,
   input  logic        fifo_rd_empty,
   input  logic        fifo_almost_empty,
   output logic [15:0] txdata,
   output logic [1:0]  txcharisk,
   output logic        pkt_busy,
   output logic [15:0] pkt_cnt,
   output logic [15:0] underrun_cnt
);

   // Link control words. Byte 0 ([7:0]) goes out first; charisk bit0 flags it.
   localparam logic [15:0] IDLE_WORD = 16'h50BC;   // K28.5, D16.2
   localparam logic [7:0]  SOP_CHAR  = 8'hFB;      // K27.7
   localparam logic [15:0] EOP_WORD  = 16'h00FD;   // K29.7, D0.0
   localparam logic [1:0]  K_LOW     = 2'b01;
   localparam logic [1:0]  K_NONE    = 2'b00;

   localparam logic [10:0] PKT_LEN   = 11'(PKT_WORDS);
   localparam logic [10:0] PKT_LAST  = 11'(PKT_WORDS - 1);
   localparam logic [7:0]  GAP_LAST  = 8'(IDLE_GAP - 1);

   // Each state decides the word that appears on txdata one cycle later.
   typedef enum logic [2:0] {
      S_IDLE,
      S_SOP,
      S_PAYLOAD,
      S_CSUM,
      S_EOP,
      S_GAP
   } state_t;

   state_t      state_q,        state_d;
   logic [10:0] issued_q,       issued_d;      // reads issued this packet
   logic [10:0] delivered_q,    delivered_d;   // payload words placed on txdata
   logic        rd_vld_q,       rd_vld_d;      // fifo_rd_data holds a requested word
   logic [15:0] csum_q,         csum_d;
   logic [7:0]  seq_q,          seq_d;
   logic [7:0]  gap_q,          gap_d;
   logic [15:0] txdata_q,       txdata_d;
   logic [1:0]  txcharisk_q,    txcharisk_d;
   logic        pkt_busy_q,     pkt_busy_d;
   logic [15:0] pkt_cnt_q,      pkt_cnt_d;
   logic [15:0] underrun_cnt_q, underrun_cnt_d;

   logic        rd_window;
   logic        rd_en;

   // Read strobe: the enable window comes from registered state. It is gated
   // by the live empty flag because a strobe registered one cycle earlier
   // could not see a word that the previous read had just taken, and it would
   // then read an empty FIFO.
   always_comb begin
      rd_window = ((state_q == S_SOP) || (state_q == S_PAYLOAD)) && (issued_q < PKT_LEN);
      rd_en     = rd_window && !fifo_rd_empty;
   end

   // Next-state, packet bookkeeping and the next registered output word.
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves one unassigned, which would infer a latch.
      state_d        = state_q;
      issued_d       = issued_q + {10'd0, rd_en};
      delivered_d    = delivered_q;
      rd_vld_d       = rd_en;
      csum_d         = csum_q;
      seq_d          = seq_q;
      gap_d          = gap_q;
      txdata_d       = IDLE_WORD;
      txcharisk_d    = K_LOW;
      pkt_busy_d     = 1'b0;
      pkt_cnt_d      = pkt_cnt_q;
      underrun_cnt_d = underrun_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            issued_d    = '0;
            delivered_d = '0;
            if (link_ready && !fifo_almost_empty) begin
               state_d = S_SOP;
            end
         end

         // The first payload read may already go out in this cycle.
         S_SOP: begin
            txdata_d    = {seq_q, SOP_CHAR};
            txcharisk_d = K_LOW;
            pkt_busy_d  = 1'b1;
            csum_d      = '0;
            state_d     = S_PAYLOAD;
         end

         S_PAYLOAD: begin
            pkt_busy_d = 1'b1;
            if (rd_vld_q) begin
               txdata_d    = fifo_rd_data;
               txcharisk_d = K_NONE;
               csum_d      = csum_q + fifo_rd_data;
               delivered_d = delivered_q + 11'd1;
               if (delivered_q == PKT_LAST) begin
                  state_d = S_CSUM;
               end
            end else if (underrun_cnt_q != 16'hFFFF) begin
               // Fill slot: the idle comes from the defaults; only count it.
               underrun_cnt_d = underrun_cnt_q + 16'd1;
            end
         end

         S_CSUM: begin
            txdata_d    = csum_q;
            txcharisk_d = K_NONE;
            pkt_busy_d  = 1'b1;
            state_d     = S_EOP;
         end

         S_EOP: begin
            txdata_d    = EOP_WORD;
            txcharisk_d = K_LOW;
            pkt_busy_d  = 1'b1;
            pkt_cnt_d   = pkt_cnt_q + 16'd1;
            seq_d       = seq_q + 8'd1;
            gap_d       = '0;
            state_d     = S_GAP;
         end

         // Idles come from the defaults. S_IDLE then adds at least one more
         // idle before the next start decision.
         S_GAP: begin
            gap_d = gap_q + 8'd1;
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers. Reset drops any read data still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         issued_q       <= '0;
         delivered_q    <= '0;
         rd_vld_q       <= 1'b0;
         csum_q         <= '0;
         seq_q          <= '0;
         gap_q          <= '0;
         txdata_q       <= IDLE_WORD;
         txcharisk_q    <= K_LOW;
         pkt_busy_q     <= 1'b0;
         pkt_cnt_q      <= '0;
         underrun_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so that every flop samples the values
         // from before the edge, whatever order the statements are in.
         state_q        <= state_d;
         issued_q       <= issued_d;
         delivered_q    <= delivered_d;
         rd_vld_q       <= rd_vld_d;
         csum_q         <= csum_d;
         seq_q          <= seq_d;
         gap_q          <= gap_d;
         txdata_q       <= txdata_d;
         txcharisk_q    <= txcharisk_d;
         pkt_busy_q     <= pkt_busy_d;
         pkt_cnt_q      <= pkt_cnt_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   assign fifo_rd_en   = rd_en;
   assign txdata       = txdata_q;
   assign txcharisk    = txcharisk_q;
   assign pkt_busy     = pkt_busy_q;
   assign pkt_cnt      = pkt_cnt_q;
   assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_hsst_tx_framer.sv
// Testbench for hsst_tx_framer.
// dut  : PKT_WORDS=256, IDLE_GAP=4 (reset, idle hold, full packet, underrun, mid-packet reset)
// dut2 : PKT_WORDS=2,   IDLE_GAP=1 (sequence number wrap over 257 packets)
// Each instance reads from its own small FIFO model with a 1-cycle read latency.

module tb_hsst_tx_framer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- dut (256-word packets) ----------------
   logic        rst = 1'b1;
   logic        link_ready = 1'b0;
   logic        rd_en0;
   logic [15:0] rd_data0 = '0;
   logic        empty0, aempty0;
   logic [15:0] txdata0;
   logic [1:0]  txk0;
   logic        busy0;
   logic [15:0] pkt_cnt0, urun0;

   hsst_tx_framer #(.PKT_WORDS(256), .IDLE_GAP(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .link_ready        (link_ready),
      .fifo_rd_en        (rd_en0),
      .fifo_rd_data      (rd_data0),
      .fifo_rd_empty     (empty0),
      .fifo_almost_empty (aempty0),
      .txdata            (txdata0),
      .txcharisk         (txk0),
      .pkt_busy          (busy0),
      .pkt_cnt           (pkt_cnt0),
      .underrun_cnt      (urun0)
   );

   // ---------------- dut2 (2-word packets) ----------------
   logic        rst2 = 1'b1;
   logic        link2 = 1'b0;
   logic        rd_en1;
   logic [15:0] rd_data1 = '0;
   logic        empty1, aempty1;
   logic [15:0] txdata1;
   logic [1:0]  txk1;
   logic        busy1;
   logic [15:0] pkt_cnt1, urun1;

   hsst_tx_framer #(.PKT_WORDS(2), .IDLE_GAP(1)) dut2 (
      .clk               (clk),
      .rst               (rst2),
      .link_ready        (link2),
      .fifo_rd_en        (rd_en1),
      .fifo_rd_data      (rd_data1),
      .fifo_rd_empty     (empty1),
      .fifo_almost_empty (aempty1),
      .txdata            (txdata1),
      .txcharisk         (txk1),
      .pkt_busy          (busy1),
      .pkt_cnt           (pkt_cnt1),
      .underrun_cnt      (urun1)
   );

   // ---------------- FIFO models ----------------
   logic [15:0] mem0 [4096];
   logic [15:0] mem1 [4096];
   int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
   int rd_err0 = 0, rd_err1 = 0;   // reads issued while the model was empty

   assign empty0  = (wr0 == rd0);
   assign aempty0 = ((wr0 - rd0) <= 4);
   assign empty1  = (wr1 == rd1);
   assign aempty1 = ((wr1 - rd1) <= 4);

   always @(posedge clk) begin
      if (rst) begin
         rd0 <= wr0;
      end else if (rd_en0) begin
         if (wr0 == rd0) rd_err0 <= rd_err0 + 1;
         rd_data0 <= mem0[rd0 % 4096];
         rd0      <= rd0 + 1;
      end
   end

   always @(posedge clk) begin
      if (rst2) begin
         rd1 <= wr1;
      end else if (rd_en1) begin
         if (wr1 == rd1) rd_err1 <= rd_err1 + 1;
         rd_data1 <= mem1[rd1 % 4096];
         rd1      <= rd1 + 1;
      end
   end

   task automatic push0(input logic [15:0] v);
      mem0[wr0 % 4096] = v;
      wr0 = wr0 + 1;
   endtask

   task automatic push1(input logic [15:0] v);
      mem1[wr1 % 4096] = v;
      wr1 = wr1 + 1;
   endtask

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits for an SOP on dut, then checks a full packet whose payload is
   // 0..255. Returns the number of fill idles seen inside the payload.
   task automatic get_pkt(input string tag, input logic [7:0] exp_seq,
                          input logic [15:0] exp_cnt, output int fills);
      int n;
      int got;
      int errs;
      n = 0; got = 0; errs = 0; fills = 0;
      while (!(txk0 == 2'b01 && txdata0[7:0] == 8'hFB) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_sop_seen"}, 32'(n < 3000), 32'd1);
      check({tag, "_sop_word"}, 32'(txdata0), 32'({exp_seq, 8'hFB}));
      check({tag, "_sop_busy"}, 32'(busy0), 32'd1);
      n = 0;
      while (got < 256 && n < 3000) begin
         @(negedge clk);
         n++;
         if (txk0 == 2'b01 && txdata0 == 16'h50BC) begin
            fills++;
         end else begin
            if (txk0 != 2'b00 || txdata0 != 16'(got)) errs++;
            got++;
         end
      end
      check({tag, "_payload_len"}, 32'(got), 32'd256);
      check({tag, "_payload_order_errs"}, 32'(errs), 32'd0);
      @(negedge clk);
      check({tag, "_csum"}, 32'({txk0, txdata0}), 32'({2'b00, 16'h7F80}));
      @(negedge clk);
      check({tag, "_eop"}, 32'({txk0, txdata0}), 32'({2'b01, 16'h00FD}));
      check({tag, "_eop_busy"}, 32'(busy0), 32'd1);
      check({tag, "_pkt_cnt"}, 32'(pkt_cnt0), 32'(exp_cnt));
      errs = 0;
      repeat (4) begin
         @(negedge clk);
         if (!(txdata0 == 16'h50BC && txk0 == 2'b01 && !busy0)) errs++;
      end
      check({tag, "_gap_idle_errs"}, 32'(errs), 32'd0);
   endtask

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int errs;
      int fills;
      int seq_errs;
      int word_errs;
      logic [7:0]  last_seq;
      logic [15:0] e0, e1;

      // ---- T1: reset held 10 cycles with link down ----
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (rd_en0) n++;
      end
      check("t1_rd_en_in_reset", 32'(n), 32'd0);
      check("t1_txdata", 32'(txdata0), 32'h50BC);
      check("t1_txcharisk", 32'(txk0), 32'd1);
      check("t1_pkt_busy", 32'(busy0), 32'd0);
      check("t1_pkt_cnt", 32'(pkt_cnt0), 32'd0);
      check("t1_underrun_cnt", 32'(urun0), 32'd0);
      rst  = 1'b0;
      rst2 = 1'b0;

      // ---- T3: FIFO loaded, link down for 100 cycles ----
      for (int i = 0; i < 256; i++) push0(16'(i));
      n = 0; errs = 0;
      repeat (100) begin
         @(negedge clk);
         if (rd_en0) n++;
         if (!(txdata0 == 16'h50BC && txk0 == 2'b01)) errs++;
      end
      check("t3_rd_en_link_down", 32'(n), 32'd0);
      check("t3_non_idle_words", 32'(errs), 32'd0);
      link_ready = 1'b1;
      n = 0;
      while (!(txk0 == 2'b01 && txdata0[7:0] == 8'hFB) && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("t3_sop_within_2", 32'(n <= 2), 32'd1);

      // ---- T2: one complete packet from the preloaded 0..255 ----
      get_pkt("t2", 8'h00, 16'd1, fills);
      check("t2_fills", 32'(fills), 32'd0);
      check("t2_underrun_cnt", 32'(urun0), 32'd0);

      // ---- T4: 10 words, stall, then the remaining 246 ----
      fork
         begin
            int m;
            for (int i = 0; i < 10; i++) push0(16'(i));
            m = 0;
            while (rd0 != wr0 && m < 2000) begin
               @(negedge clk);
               m++;
            end
            repeat (5) @(negedge clk);
            for (int i = 10; i < 256; i++) push0(16'(i));
         end
         get_pkt("t4", 8'h01, 16'd2, fills);
      join
      check("t4_fills_ge_5", 32'(fills >= 5), 32'd1);
      check("t4_underrun_cnt", 32'(urun0), 32'(fills));
      check("t4_no_empty_reads", 32'(rd_err0), 32'd0);

      // ---- T5: 257 two-word packets on dut2, sequence wraps ----
      for (int i = 0; i < 600; i++) push1(16'hF000 + 16'(i));
      link2 = 1'b1;
      seq_errs = 0; word_errs = 0; last_seq = 8'hAA;
      for (int p = 0; p < 257; p++) begin
         n = 0;
         while (!(txk1 == 2'b01 && txdata1[7:0] == 8'hFB) && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (n >= 200) seq_errs++;
         if (txdata1[15:8] != p[7:0]) seq_errs++;
         last_seq = txdata1[15:8];
         e0 = 16'hF000 + 16'(2 * p);
         e1 = e0 + 16'd1;
         @(negedge clk);
         if (txk1 != 2'b00 || txdata1 != e0) word_errs++;
         @(negedge clk);
         if (txk1 != 2'b00 || txdata1 != e1) word_errs++;
         @(negedge clk);
         if (txk1 != 2'b00 || txdata1 != 16'(e0 + e1)) word_errs++;
         @(negedge clk);
         if (txk1 != 2'b01 || txdata1 != 16'h00FD) word_errs++;
      end
      link2 = 1'b0;
      repeat (10) @(negedge clk);
      check("t5_seq_errs", 32'(seq_errs), 32'd0);
      check("t5_word_errs", 32'(word_errs), 32'd0);
      check("t5_last_seq_wrapped", 32'(last_seq), 32'd0);
      check("t5_pkt_cnt", 32'(pkt_cnt1), 32'd257);
      check("t5_underrun_cnt", 32'(urun1), 32'd0);
      check("t5_no_empty_reads", 32'(rd_err1), 32'd0);

      // ---- T6: reset asserted while payload word 100 is on the lane ----
      for (int i = 0; i < 256; i++) push0(16'(i));
      n = 0;
      while (!(txk0 == 2'b01 && txdata0[7:0] == 8'hFB) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t6_sop_word", 32'(txdata0), 32'h02FB);
      n = 0;
      while (!(txk0 == 2'b00 && txdata0 == 16'd100) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t6_word100_seen", 32'(n < 2000), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t6_txdata", 32'(txdata0), 32'h50BC);
      check("t6_txcharisk", 32'(txk0), 32'd1);
      check("t6_rd_en", 32'(rd_en0), 32'd0);
      check("t6_pkt_busy", 32'(busy0), 32'd0);
      check("t6_pkt_cnt", 32'(pkt_cnt0), 32'd0);
      check("t6_underrun_cnt", 32'(urun0), 32'd0);
      rst = 1'b0;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (rd_en0 || busy0) n++;
      end
      check("t6_quiet_after_reset", 32'(n), 32'd0);
      check("t6_no_empty_reads", 32'(rd_err0), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
